// File: rtl/rvm_shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer for the multi-cycle core.
// Shifts at most STEP bits per cycle through a narrow barrel stage.
module rvm_shift_seq #(
    parameter int STEP = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_lhs,
    input  logic [4:0]  req_rhs,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    if (STEP < 1 || STEP > 16 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("rvm_shift_seq: STEP must be a power of two in 1..16");
    end

    localparam logic [4:0] STEP_W = 5'(STEP);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [4:0]  rem, rem_nxt;
    logic [1:0]  op, op_nxt;
    logic [4:0]  amt;
    logic [4:0]  rem_dec;
    logic [31:0] shifted;
    logic        accept;

    assign req_ready  = (state == IDLE) & ~flush & ~g_reset;
    assign accept     = req_valid & req_ready;
    assign rsp_valid  = (state == RESP);
    assign rsp_result = rsp_valid ? acc : 32'h0;
    assign busy       = (state != IDLE);

    // One narrow barrel step: never more than STEP positions per cycle.
    assign amt     = (rem < STEP_W) ? rem : STEP_W;
    assign rem_dec = rem - amt;

    always_comb begin
        shifted = acc;
        unique case (op)
            OP_SLL:  shifted = acc << amt;
            OP_SRL:  shifted = acc >> amt;
            OP_SRA:  shifted = 32'($signed(acc) >>> amt);
            default: shifted = acc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        op_nxt    = op;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    op_nxt  = req_op;
                    acc_nxt = req_lhs;
                    rem_nxt = req_rhs;
                    if (req_op == OP_NOP) begin
                        acc_nxt   = 32'h0;
                        state_nxt = RESP;
                    end else if (req_rhs == 5'd0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_nxt = shifted;
                rem_nxt = rem_dec;
                if (rem_dec == 5'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A flush kills the op even if the response is being taken.
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= IDLE;
            acc   <= 32'h0;
            rem   <= 5'd0;
            op    <= OP_NOP;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            op    <= op_nxt;
        end
    end

endmodule

// File: tb/tb_rvm_shift_seq.sv
// Bench for rvm_shift_seq: directed cases plus random ops
// checked against an arithmetic shift model.
module tb_rvm_shift_seq;

    localparam int STEP = 4;

    logic        g_clk;
    logic        g_reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_lhs;
    logic [4:0]  req_rhs;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    rvm_shift_seq #(.STEP(STEP)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_lhs    (req_lhs),
        .req_rhs    (req_rhs),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [4:0] s);
        case (op)
            2'b01:   return a << s;
            2'b10:   return a >> s;
            2'b11:   return 32'($signed(a) >>> s);
            default: return 32'h0;
        endcase
    endfunction

    // Cycles from the accepting edge until the response appears.
    function automatic int ref_lat(input logic [1:0] op, input logic [4:0] s);
        if (op == 2'b00 || s == 5'd0) return 0;
        return (int'(s) + STEP - 1) / STEP;
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] lhs,
                        input logic [4:0] rhs);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_lhs   = lhs;
        req_rhs   = rhs;
        while (!req_ready && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        chk("accept", {31'b0, req_ready}, 32'd1);
        @(posedge g_clk);
        @(negedge g_clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_lhs   = $urandom;
        req_rhs   = 5'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge g_clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] lhs,
                          input logic [4:0] rhs, input int bp);
        int          lat;
        logic [31:0] exp;
        exp = ref_shift(op, lhs, rhs);
        rsp_ready = (bp == 0);
        send(op, lhs, rhs);
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(ref_lat(op, rhs)));
        chk("result", rsp_result, exp);
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_op    = 2'($urandom);
            req_lhs   = $urandom;
            req_rhs   = 5'($urandom);
            @(negedge g_clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_result", rsp_result, exp);
            chk("hold_rdy", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge g_clk);
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("rdy_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [1:0] rop;
        g_reset   = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_lhs   = 32'h0;
        req_rhs   = 5'd0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_rdy", {31'b0, req_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'h0);
        @(negedge g_clk);
        g_reset = 1'b0;
        @(negedge g_clk);
        chk("idle_rdy", {31'b0, req_ready}, 32'd1);

        run_op(2'b01, 32'h0000_0001, 5'd31, 0);
        run_op(2'b11, 32'h8000_0000, 5'd4, 0);
        run_op(2'b10, 32'h8000_0000, 5'd4, 0);
        run_op(2'b11, 32'h8000_0001, 5'd31, 0);
        run_op(2'b10, 32'hF000_000F, 5'd0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(2'b01, 32'h1234_5678, 5'd8, 5);

        // Flush on the third SHIFT cycle.
        send(2'b01, 32'h0000_0001, 5'd20);
        @(negedge g_clk);
        @(negedge g_clk);
        flush = 1'b1;
        @(negedge g_clk);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        chk("fl_rdy", {31'b0, req_ready}, 32'd0);
        // Request concurrent with flush in IDLE must wait.
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_lhs   = 32'hFF00_0000;
        req_rhs   = 5'd8;
        @(negedge g_clk);
        chk("fl_noacc", {31'b0, busy}, 32'd0);
        seen = 0;
        flush = 1'b0;
        run_op(2'b10, 32'hFF00_0000, 5'd8, 0);

        // Flush while the response is offered kills it.
        rsp_ready = 1'b0;
        send(2'b01, 32'h0000_00F0, 5'd0);
        wait_rsp(lat);
        chk("flr_valid", {31'b0, rsp_valid}, 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge g_clk);
        chk("flr_drop", {31'b0, rsp_valid}, 32'd0);
        chk("flr_res", rsp_result, 32'h0);
        flush = 1'b0;

        // Asynchronous reset mid-SHIFT.
        send(2'b01, 32'h0000_0001, 5'd31);
        @(negedge g_clk);
        #2 g_reset = 1'b1;
        #1;
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_rdy", {31'b0, req_ready}, 32'd0);
        chk("ar_valid", {31'b0, rsp_valid}, 32'd0);
        chk("ar_res", rsp_result, 32'h0);
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        chk("ar_idle", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge g_clk);
            if (rsp_valid) seen++;
        end
        chk("ar_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            run_op(rop, $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
